// File: rtl/axi_tri_write_slave.sv
// axi_tri_write_slave
// AXI4-Lite write-channel responder that gathers one triangle as six 32-bit
// words (offsets 0x00-0x14), then pushes the assembled 192-bit descriptor
// into the triangle FIFO. The write response is withheld until the FIFO
// accepts the descriptor, so FIFO backpressure reaches the host.
// Optional build macro: TRI_AREA_CHECK_EN rejects a zero inv_area (word 5)
// with SLVERR and does not push that descriptor.
//
// state  | meaning
// IDLE   | accepting AW and W independently until both are latched
// COMMIT | decode address, store word, pick error/push/response path
// PUSH   | tri_valid held until the FIFO takes the descriptor
// RESP   | axi_bvalid held until the master takes the response

module axi_tri_write_slave #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 5,
    parameter int TRI_WORDS        = 6
) (
    input  logic                                  axi_aclk,
    input  logic                                  axi_areset,
    input  logic [C_AXI_ADDR_WIDTH-1:0]           axi_awaddr,
    input  logic                                  axi_awvalid,
    output logic                                  axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0]           axi_wdata,
    input  logic                                  axi_wvalid,
    output logic                                  axi_wready,
    output logic [1:0]                            axi_bresp,
    output logic                                  axi_bvalid,
    input  logic                                  axi_bready,
    output logic [TRI_WORDS*C_AXI_DATA_WIDTH-1:0] tri_data,
    output logic                                  tri_valid,
    input  logic                                  tri_ready,
    output logic [15:0]                           tri_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COMMIT = 2'd1;
    localparam logic [1:0] S_PUSH   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] LAST_IDX = 3'(TRI_WORDS - 1);

    logic [1:0]                            r_state;
    logic                                  r_aw_latched;
    logic                                  r_w_latched;
    logic [C_AXI_ADDR_WIDTH-1:0]           r_addr;
    logic [C_AXI_DATA_WIDTH-1:0]           r_wdata;
    logic [C_AXI_DATA_WIDTH-1:0]           r_word [TRI_WORDS];
    logic [TRI_WORDS*C_AXI_DATA_WIDTH-1:0] r_tri_data;
    logic [15:0]                           r_tri_count;
    logic [1:0]                            r_bresp;

    logic                                  w_aw_hs;
    logic                                  w_w_hs;
    logic [2:0]                            w_idx;
    logic                                  w_addr_err;
    logic [TRI_WORDS*C_AXI_DATA_WIDTH-1:0] w_tri_next;

    // Readies are forced low while reset is asserted, not just after it.
    assign axi_awready = !axi_areset && (r_state == S_IDLE) && !r_aw_latched;
    assign axi_wready  = !axi_areset && (r_state == S_IDLE) && !r_w_latched;

    assign w_aw_hs    = axi_awvalid && axi_awready;
    assign w_w_hs     = axi_wvalid && axi_wready;
    assign w_idx      = r_addr[4:2];
    assign w_addr_err = (r_addr[1:0] != 2'b00) || (w_idx > LAST_IDX);

    assign axi_bvalid = (r_state == S_RESP);
    assign axi_bresp  = r_bresp;
    assign tri_valid  = (r_state == S_PUSH);
    assign tri_data   = r_tri_data;
    assign tri_count  = r_tri_count;

    // Descriptor image with the incoming last word spliced over the stored one.
    always_comb begin
        w_tri_next = '0;
        for (int i = 0; i < TRI_WORDS; i++) begin
            if (i == TRI_WORDS - 1)
                w_tri_next[i*C_AXI_DATA_WIDTH +: C_AXI_DATA_WIDTH] = r_wdata;
            else
                w_tri_next[i*C_AXI_DATA_WIDTH +: C_AXI_DATA_WIDTH] = r_word[i];
        end
    end

    // Sequencer: latch AW/W, commit the word, push on the last word, respond.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_state      <= S_IDLE;
            r_aw_latched <= 1'b0;
            r_w_latched  <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_tri_data   <= '0;
            r_tri_count  <= '0;
            r_bresp      <= RESP_OKAY;
            for (int i = 0; i < TRI_WORDS; i++)
                r_word[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_latched <= 1'b1;
                        r_addr       <= axi_awaddr;
                    end
                    if (w_w_hs) begin
                        r_w_latched <= 1'b1;
                        r_wdata     <= axi_wdata;
                    end
                    if (r_aw_latched && r_w_latched)
                        r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    if (w_addr_err) begin
                        r_bresp <= RESP_SLVERR;
                        r_state <= S_RESP;
                    end else begin
                        r_word[w_idx] <= r_wdata;
                        r_bresp       <= RESP_OKAY;
                        if (w_idx == LAST_IDX) begin
`ifdef TRI_AREA_CHECK_EN
                            // Zero inv_area is a degenerate triangle: keep the
                            // word but never hand it to the rasterizer.
                            if (r_wdata == '0) begin
                                r_bresp <= RESP_SLVERR;
                                r_state <= S_RESP;
                            end else begin
                                r_tri_data <= w_tri_next;
                                r_state    <= S_PUSH;
                            end
`else
                            r_tri_data <= w_tri_next;
                            r_state    <= S_PUSH;
`endif
                        end else begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_PUSH: begin
                    if (tri_ready) begin
                        r_tri_count <= r_tri_count + 16'd1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (axi_bready) begin
                        r_aw_latched <= 1'b0;
                        r_w_latched  <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_tri_write_slave.sv
// Directed bench for axi_tri_write_slave; honours TRI_AREA_CHECK_EN if defined.
module tb_axi_tri_write_slave;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [191:0] tri_data;
    logic         tri_valid;
    logic         tri_ready;
    logic [15:0]  tri_count;

    int checks = 0;
    int errors = 0;
    int push_cnt = 0;
    logic [191:0] last_tri = '0;
    logic [15:0]  exp_count = 16'd0;

    logic [31:0] w1 [6] = '{32'h00140028, 32'h008C0032, 32'h00320078,
                            32'h00078028, 32'h00E00032, 32'h00028F5C};
    logic [31:0] w2 [3] = '{32'h0A0B0C0D, 32'h11223344, 32'h55667788};
    logic [31:0] w3 [6] = '{32'h00010002, 32'h00030004, 32'h00050006,
                            32'h00070008, 32'h0009000A, 32'h000B000C};

    axi_tri_write_slave dut (
        .axi_aclk(clk), .axi_areset(rst),
        .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready),
        .axi_wdata(wdata), .axi_wvalid(wvalid), .axi_wready(wready),
        .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
        .tri_data(tri_data), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_count(tri_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && tri_valid && tri_ready) begin
            push_cnt = push_cnt + 1;
            last_tri = tri_data;
        end
    end

    // mode 0: AW and W together, 1: W one cycle before AW, 2: AW before W
    task automatic send(input logic [4:0] a, input logic [31:0] d, input int mode);
        bit aw_done = 0, w_done = 0, aw_f, w_f;
        int n = 0;
        awaddr = a;
        wdata = d;
        awvalid = (mode != 1);
        wvalid = (mode != 2);
        while (!(aw_done && w_done) && n < 50) begin
            @(negedge clk);
            aw_f = awvalid && awready;
            w_f = wvalid && wready;
            @(posedge clk); #1;
            if (aw_f) begin aw_done = 1; awvalid = 0; end
            if (w_f) begin w_done = 1; wvalid = 0; end
            if (mode == 1 && w_done && !aw_done) awvalid = 1;
            if (mode == 2 && aw_done && !w_done) wvalid = 1;
            n++;
        end
        awvalid = 0;
        wvalid = 0;
        if (!(aw_done && w_done)) begin
            checks++; errors++;
            $display("FAIL handshake_timeout addr %0h got aw=%0b w=%0b want both", a, aw_done, w_done);
        end
    endtask

    // Counts cycles from the last handshake edge to bvalid, then takes the response.
    task automatic wait_b(output logic [1:0] r, output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            if (bvalid) break;
            @(posedge clk);
            lat++;
        end
        if (!bvalid) begin
            checks++; errors++;
            $display("FAIL bvalid_timeout got 0 want 1");
        end
        r = bresp;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input int mode,
                      output logic [1:0] r, output int lat);
        send(a, d, mode);
        wait_b(r, lat);
    endtask

    task automatic test_reset;
        rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wvalid = 0;
        bready = 1; tri_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (awready !== 1'b0) begin errors++; $display("FAIL rst_awready got %0b want 0", awready); end
        checks++; if (wready !== 1'b0) begin errors++; $display("FAIL rst_wready got %0b want 0", wready); end
        checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %0b want 0", bvalid); end
        checks++; if (tri_valid !== 1'b0) begin errors++; $display("FAIL rst_tri_valid got %0b want 0", tri_valid); end
        checks++; if (tri_count !== 16'd0) begin errors++; $display("FAIL rst_tri_count got %0h want 0", tri_count); end
        checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL rst_bresp got %0b want 0", bresp); end
        checks++; if (tri_data !== 192'd0) begin errors++; $display("FAIL rst_tri_data got %0h want 0", tri_data); end
        rst = 0;
        #1;
        checks++; if (awready !== 1'b1) begin errors++; $display("FAIL post_rst_awready got %0b want 1", awready); end
        checks++; if (wready !== 1'b1) begin errors++; $display("FAIL post_rst_wready got %0b want 1", wready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [1:0] r;
        int lat;
        logic [191:0] exp;
        push_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            wr(5'(i * 4), w1[i], 0, r, lat);
            checks++; if (r !== 2'b00) begin errors++; $display("FAIL basic_bresp word%0d got %0b want 00", i, r); end
            checks++; if (lat != ((i == 5) ? 3 : 2)) begin errors++; $display("FAIL basic_latency word%0d got %0d want %0d", i, lat, (i == 5) ? 3 : 2); end
        end
        exp_count = exp_count + 16'd1;
        exp = {w1[5], w1[4], w1[3], w1[2], w1[1], w1[0]};
        @(negedge clk);
        checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL basic_bvalid_drop got %0b want 0", bvalid); end
        checks++; if (push_cnt != 1) begin errors++; $display("FAIL basic_push_cnt got %0d want 1", push_cnt); end
        checks++; if (last_tri[31:0] !== 32'h00140028) begin errors++; $display("FAIL basic_word0 got %0h want 00140028", last_tri[31:0]); end
        checks++; if (last_tri[191:160] !== 32'h00028F5C) begin errors++; $display("FAIL basic_word5 got %0h want 00028f5c", last_tri[191:160]); end
        checks++; if (last_tri !== exp) begin errors++; $display("FAIL basic_tri_data got %0h want %0h", last_tri, exp); end
        checks++; if (tri_count !== exp_count) begin errors++; $display("FAIL basic_tri_count got %0h want %0h", tri_count, exp_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_orders;
        logic [1:0] r;
        int lat;
        logic [191:0] exp;
        push_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            wr(5'(i * 4), w2[i], (i == 0) ? 1 : ((i == 1) ? 2 : 0), r, lat);
            checks++; if (r !== 2'b00) begin errors++; $display("FAIL order_bresp word%0d got %0b want 00", i, r); end
            checks++; if (lat != 2) begin errors++; $display("FAIL order_latency word%0d got %0d want 2", i, lat); end
            @(negedge clk);
            checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL order_single_bvalid word%0d got %0b want 0", i, bvalid); end
            @(posedge clk); #1;
        end
        wr(5'h14, 32'h00011111, 0, r, lat);
        exp_count = exp_count + 16'd1;
        exp = {32'h00011111, w1[4], w1[3], w2[2], w2[1], w2[0]};
        @(negedge clk);
        checks++; if (last_tri !== exp) begin errors++; $display("FAIL order_tri_data got %0h want %0h", last_tri, exp); end
        checks++; if (push_cnt != 1) begin errors++; $display("FAIL order_push_cnt got %0d want 1", push_cnt); end
        checks++; if (tri_count !== exp_count) begin errors++; $display("FAIL order_tri_count got %0h want %0h", tri_count, exp_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        logic [191:0] exp;
        int n = 0;
        exp = {32'h00033333, w1[4], w1[3], w2[2], w2[1], w2[0]};
        tri_ready = 0;
        push_cnt = 0;
        send(5'h14, 32'h00033333, 0);
        do begin @(negedge clk); n++; end while (!tri_valid && n < 10);
        for (int k = 0; k < 20; k++) begin
            checks++; if (tri_valid !== 1'b1) begin errors++; $display("FAIL bp_tri_valid cyc%0d got %0b want 1", k, tri_valid); end
            checks++; if (tri_data !== exp) begin errors++; $display("FAIL bp_tri_data cyc%0d got %0h want %0h", k, tri_data, exp); end
            checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL bp_bvalid cyc%0d got %0b want 0", k, bvalid); end
            checks++; if (awready !== 1'b0) begin errors++; $display("FAIL bp_awready cyc%0d got %0b want 0", k, awready); end
            @(negedge clk);
        end
        @(posedge clk); #1;
        tri_ready = 1;
        @(negedge clk);
        checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL bp_bvalid_release got %0b want 0", bvalid); end
        @(negedge clk);
        checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL bp_bvalid_after got %0b want 1", bvalid); end
        checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL bp_bresp got %0b want 00", bresp); end
        @(posedge clk); #1;
        exp_count = exp_count + 16'd1;
        checks++; if (push_cnt != 1) begin errors++; $display("FAIL bp_push_cnt got %0d want 1", push_cnt); end
        checks++; if (tri_count !== exp_count) begin errors++; $display("FAIL bp_tri_count got %0h want %0h", tri_count, exp_count); end
    endtask

    task automatic test_errors;
        logic [1:0] r;
        int lat;
        logic [191:0] exp;
        push_cnt = 0;
        wr(5'h18, 32'hDEADBEEF, 0, r, lat);
        checks++; if (r !== 2'b10) begin errors++; $display("FAIL err_0x18_bresp got %0b want 10", r); end
        checks++; if (lat != 2) begin errors++; $display("FAIL err_0x18_latency got %0d want 2", lat); end
        wr(5'h02, 32'hCAFEF00D, 2, r, lat);
        checks++; if (r !== 2'b10) begin errors++; $display("FAIL err_0x02_bresp got %0b want 10", r); end
        checks++; if (push_cnt != 0) begin errors++; $display("FAIL err_push_cnt got %0d want 0", push_cnt); end
        checks++; if (tri_count !== exp_count) begin errors++; $display("FAIL err_tri_count got %0h want %0h", tri_count, exp_count); end
        wr(5'h14, 32'h00044444, 0, r, lat);
        exp_count = exp_count + 16'd1;
        exp = {32'h00044444, w1[4], w1[3], w2[2], w2[1], w2[0]};
        checks++; if (r !== 2'b00) begin errors++; $display("FAIL resubmit_bresp got %0b want 00", r); end
        checks++; if (lat != 3) begin errors++; $display("FAIL resubmit_latency got %0d want 3", lat); end
        checks++; if (last_tri !== exp) begin errors++; $display("FAIL resubmit_tri_data got %0h want %0h", last_tri, exp); end
    endtask

    task automatic test_area;
        logic [1:0] r;
        int lat;
        push_cnt = 0;
        wr(5'h14, 32'h0, 0, r, lat);
`ifdef TRI_AREA_CHECK_EN
        checks++; if (r !== 2'b10) begin errors++; $display("FAIL area_bresp got %0b want 10", r); end
        checks++; if (lat != 2) begin errors++; $display("FAIL area_latency got %0d want 2", lat); end
        checks++; if (push_cnt != 0) begin errors++; $display("FAIL area_push_cnt got %0d want 0", push_cnt); end
`else
        exp_count = exp_count + 16'd1;
        checks++; if (r !== 2'b00) begin errors++; $display("FAIL area_bresp got %0b want 00", r); end
        checks++; if (lat != 3) begin errors++; $display("FAIL area_latency got %0d want 3", lat); end
        checks++; if (push_cnt != 1) begin errors++; $display("FAIL area_push_cnt got %0d want 1", push_cnt); end
        checks++; if (last_tri[191:160] !== 32'h0) begin errors++; $display("FAIL area_word5 got %0h want 0", last_tri[191:160]); end
`endif
        checks++; if (tri_count !== exp_count) begin errors++; $display("FAIL area_tri_count got %0h want %0h", tri_count, exp_count); end
    endtask

    task automatic test_reset_mid_push;
        logic [1:0] r;
        int lat;
        int n = 0;
        logic [191:0] exp;
        tri_ready = 0;
        send(5'h14, 32'h00055555, 0);
        do begin @(negedge clk); n++; end while (!tri_valid && n < 10);
        checks++; if (tri_valid !== 1'b1) begin errors++; $display("FAIL rmp_in_push got %0b want 1", tri_valid); end
        #2 rst = 1;
        #1;
        checks++; if (tri_valid !== 1'b0) begin errors++; $display("FAIL rmp_tri_valid got %0b want 0", tri_valid); end
        checks++; if (tri_count !== 16'd0) begin errors++; $display("FAIL rmp_tri_count got %0h want 0", tri_count); end
        checks++; if (awready !== 1'b0) begin errors++; $display("FAIL rmp_awready got %0b want 0", awready); end
        checks++; if (wready !== 1'b0) begin errors++; $display("FAIL rmp_wready got %0b want 0", wready); end
        @(negedge clk);
        rst = 0;
        tri_ready = 1;
        #1;
        checks++; if (awready !== 1'b1) begin errors++; $display("FAIL rmp_post_awready got %0b want 1", awready); end
        checks++; if (wready !== 1'b1) begin errors++; $display("FAIL rmp_post_wready got %0b want 1", wready); end
        checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL rmp_post_bvalid got %0b want 0", bvalid); end
        @(posedge clk); #1;
        push_cnt = 0;
        wr(5'h14, 32'h00066666, 0, r, lat);
        exp = {32'h00066666, 160'd0};
        checks++; if (last_tri !== exp) begin errors++; $display("FAIL rmp_cleared_words got %0h want %0h", last_tri, exp); end
        checks++; if (tri_count !== 16'd1) begin errors++; $display("FAIL rmp_count1 got %0h want 1", tri_count); end
        for (int i = 0; i < 6; i++) wr(5'(i * 4), w3[i], 0, r, lat);
        exp = {w3[5], w3[4], w3[3], w3[2], w3[1], w3[0]};
        checks++; if (r !== 2'b00) begin errors++; $display("FAIL rmp_fresh_bresp got %0b want 00", r); end
        checks++; if (last_tri !== exp) begin errors++; $display("FAIL rmp_fresh_tri_data got %0h want %0h", last_tri, exp); end
        checks++; if (push_cnt != 2) begin errors++; $display("FAIL rmp_push_cnt got %0d want 2", push_cnt); end
        checks++; if (tri_count !== 16'd2) begin errors++; $display("FAIL rmp_count2 got %0h want 2", tri_count); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_orders;
        test_backpressure;
        test_errors;
        test_area;
        test_reset_mid_push;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
